mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for an 8-input, 1-bit, 3-bit-select mux path with enable.
- Eight requesters compete for the single output bit; the block drives the one-hot grant, the 3-bit select and the enable.
- Also provides a registered mux output with a valid flag.
- Sits between the requester bank and the downstream serial consumer, replacing free-running select logic.

---
 rtl/mux8_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter
// Brief    : Round-robin arbiter for an 8:1 single-bit mux path with a bounded
//            hold time, break-before-make grants and a registered mux output.
// Revision : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] A,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       en,
    output logic       y,
    output logic       y_valid
);

    localparam int unsigned          c_CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [c_CNT_W-1:0]   c_HOLD_LAST = c_CNT_W'(MAX_HOLD - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_illegal
            $error("mux8_rr_arbiter: MAX_HOLD must lie in 1..255");
        end
    endgenerate

    logic [0:0]         r_state;
    logic [2:0]         r_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_gnt;
    logic [2:0]         r_sel;
    logic               r_en;
    logic               r_y;
    logic               r_y_valid;

    logic               w_found;
    logic [2:0]         w_idx;
    logic [2:0]         w_cand;
    logic               w_release;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 3'd0;
        w_cand  = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            w_cand = r_ptr + 3'(k);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign w_release = !req[r_sel] || (r_cnt == c_HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_cnt     <= '0;
            r_gnt     <= 8'd0;
            r_sel     <= 3'd0;
            r_en      <= 1'b0;
            r_y       <= 1'b0;
            r_y_valid <= 1'b0;
        end else begin
            // Data path follows the grant registers by one cycle.
            r_y       <= r_en ? A[r_sel] : 1'b0;
            r_y_valid <= r_en;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= 8'h01 << w_idx;
                        r_sel   <= w_idx;
                        r_en    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end else begin
                        r_gnt <= 8'd0;
                        r_en  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_gnt   <= 8'd0;
                        r_en    <= 1'b0;
                        r_ptr   <= r_sel + 3'd1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_gnt   <= 8'd0;
                    r_en    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign en      = r_en;
    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8_rr_arbiter
// Brief    : Directed and random checks of two arbiter instances (hold 8 and
//            hold 2) against a grant-ownership reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] A;

    logic [7:0] obs_gnt   [2];
    logic [2:0] obs_sel   [2];
    logic       obs_en    [2];
    logic       obs_y     [2];
    logic       obs_yv    [2];

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the output, for how many cycles so far.
    int         c_hold  [2] = '{8, 2};
    int         m_owner [2] = '{-1, -1};
    int         m_held  [2] = '{0, 0};
    int         m_ptr   [2] = '{0, 0};
    int         m_sel   [2] = '{0, 0};
    logic       m_y     [2] = '{1'b0, 1'b0};
    logic       m_yv    [2] = '{1'b0, 1'b0};

    mux8_rr_arbiter #(.MAX_HOLD(8)) u_dut_h8 (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A),
        .gnt(obs_gnt[0]), .sel(obs_sel[0]), .en(obs_en[0]),
        .y(obs_y[0]), .y_valid(obs_yv[0])
    );

    mux8_rr_arbiter #(.MAX_HOLD(2)) u_dut_h2 (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A),
        .gnt(obs_gnt[1]), .sel(obs_sel[1]), .en(obs_en[1]),
        .y(obs_y[1]), .y_valid(obs_yv[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_owner[k] = -1;
                m_held[k]  = 0;
                m_ptr[k]   = 0;
                m_sel[k]   = 0;
                m_y[k]     = 1'b0;
                m_yv[k]    = 1'b0;
            end else begin
                m_y[k]  = (m_owner[k] >= 0) ? A[m_sel[k]] : 1'b0;
                m_yv[k] = (m_owner[k] >= 0);
                if (m_owner[k] < 0) begin
                    for (int s = 0; s < 8; s++) begin
                        if (m_owner[k] < 0 && req[(m_ptr[k] + s) % 8]) begin
                            m_owner[k] = (m_ptr[k] + s) % 8;
                            m_sel[k]   = m_owner[k];
                            m_held[k]  = 1;
                        end
                    end
                end else if (!req[m_owner[k]] || m_held[k] >= c_hold[k]) begin
                    m_ptr[k]   = (m_owner[k] + 1) % 8;
                    m_owner[k] = -1;
                    m_held[k]  = 0;
                end else begin
                    m_held[k]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("gnt[%0d]", k), obs_gnt[k],
                  (m_owner[k] >= 0) ? (8'h01 << m_owner[k]) : 8'h00);
            check($sformatf("sel[%0d]", k), 8'(obs_sel[k]), 8'(m_sel[k]));
            check($sformatf("en[%0d]", k), 8'(obs_en[k]), 8'(m_owner[k] >= 0));
            check($sformatf("y[%0d]", k), 8'(obs_y[k]), 8'(m_y[k]));
            check($sformatf("y_valid[%0d]", k), 8'(obs_yv[k]), 8'(m_yv[k]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_g;

        // Reset, then idle with all data bits high.
        rst_n = 1'b0;
        req   = 8'h00;
        A     = 8'hFF;
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        check("idle_gnt", obs_gnt[0], 8'h00);
        check("idle_y", 8'(obs_y[0]), 8'h00);

        // Single requester 5 for three cycles.
        req = 8'h20;
        A   = 8'h20;
        tick();
        check("single_gnt", obs_gnt[0], 8'h20);
        check("single_sel", 8'(obs_sel[0]), 8'd5);
        tick();
        tick();
        check("single_hold3", obs_gnt[0], 8'h20);
        req = 8'h00;
        tick();
        check("single_rel", obs_gnt[0], 8'h00);
        check("single_y", 8'(obs_y[0]), 8'h01);
        tick();
        check("single_yv_off", 8'(obs_yv[0]), 8'h00);

        // Rotation with hold 2: 0..7,0 each for 2 cycles then 1 idle.
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                exp_g = (c < 2) ? (8'h01 << (g % 8)) : 8'h00;
                check($sformatf("rot_g%0d_c%0d", g, c), obs_gnt[1], exp_g);
            end
        end

        // Timeout fairness with hold 8 between requesters 0 and 7.
        do_reset();
        req = 8'h81;
        for (int c = 0; c < 19; c++) begin
            tick();
            if (c < 8)       exp_g = 8'h01;
            else if (c == 8) exp_g = 8'h00;
            else if (c < 17) exp_g = 8'h80;
            else if (c == 17) exp_g = 8'h00;
            else             exp_g = 8'h01;
            check($sformatf("tmo_c%0d", c), obs_gnt[0], exp_g);
        end

        // Wrap-around search past requester 7.
        do_reset();
        req = 8'h40;
        tick();
        check("wrap_g6", obs_gnt[0], 8'h40);
        req = 8'h00;
        tick();
        req = 8'h09;
        tick();
        check("wrap_g0_h8", obs_gnt[0], 8'h01);
        check("wrap_g0_h2", obs_gnt[1], 8'h01);
        req = 8'h08;
        tick();
        tick();
        check("wrap_g3_h8", obs_gnt[0], 8'h08);
        check("wrap_g3_h2", obs_gnt[1], 8'h08);

        // Reset during cycle 4 of a requester-3 grant.
        do_reset();
        req = 8'h08;
        for (int c = 0; c < 4; c++) tick();
        check("mid_pre", obs_gnt[0], 8'h08);
        rst_n = 1'b0;
        tick();
        check("mid_gnt", obs_gnt[0], 8'h00);
        check("mid_en", 8'(obs_en[0]), 8'h00);
        check("mid_yv", 8'(obs_yv[0]), 8'h00);
        rst_n = 1'b1;
        req   = 8'h0C;
        tick();
        check("mid_after_h8", obs_gnt[0], 8'h04);
        check("mid_after_h2", obs_gnt[1], 8'h04);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom() & $urandom());
            A = 8'($urandom());
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
